// File: rtl/mvm_pkg.sv
// mvm_pkg: shared types and helpers for the streaming matrix-vector multiplier.
//   mvm_state_t : controller state encoding (IDLE, LOAD_A, LOAD_X, COMPUTE, OUTPUT)
//   MVM_K/P/B   : default configuration (8x8 matrix, 2 lanes, 8-bit elements)
//   CNT_*_W     : counter widths of the default configuration
//   cnt_w()     : counter width able to hold values 0..n-1 (never below 1)
//   sat_clip()  : clamps a signed value to the signed range of a given width
package mvm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_A  = 3'd1,
        ST_LOAD_X  = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_OUTPUT  = 3'd4
    } mvm_state_t;

    localparam int MVM_K = 8;
    localparam int MVM_P = 2;
    localparam int MVM_B = 8;

    // Widths for the default configuration: element index, column index and
    // group index (the group counter reaches K/P at the end of a matrix load).
    localparam int CNT_KK_W = $clog2(MVM_K * MVM_K);
    localparam int CNT_K_W  = $clog2(MVM_K);
    localparam int CNT_G_W  = $clog2(MVM_K / MVM_P + 1);

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v,
                                                    input int                 w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/mvm_lane.sv
// mvm_lane: one MAC lane. Holds the A rows r with r % P == lane, stored as
// (K/P) blocks of K words (block = row group, word = column). A registered
// bank read, a registered multiply and an accumulator form a three-stage
// pipeline; rd_en marks issued columns and travels with the data so that
// only real products are accumulated.
//   clk, reset           : clock, synchronous active-high reset (pipeline only)
//   wr_en/wr_addr/wr_data: bank write port used while loading A
//   rd_en, rd_addr       : column issue strobe and bank read address
//   x_data               : x element already aligned with the bank read data
//   clear                : zero the accumulator at the start of a row group
//   acc                  : accumulated dot product of this lane's current row
module mvm_lane
    import mvm_pkg::*;
#(
    parameter int B     = MVM_B,
    parameter int ACC_W = 2 * MVM_B + $clog2(MVM_K),
    parameter int DEPTH = (MVM_K / MVM_P) * MVM_K,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [B-1:0]            wr_data,
    input  logic                    rd_en,
    input  logic [AW-1:0]           rd_addr,
    input  logic signed [B-1:0]     x_data,
    input  logic                    clear,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [B-1:0]   bank [DEPTH];
    logic signed [B-1:0]   a_q;
    logic signed [2*B-1:0] prod_q;
    logic                  a_v;
    logic                  prod_v;

    // Bank and datapath registers keep their contents across reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            bank[wr_addr] <= wr_data;
        a_q    <= bank[rd_addr];
        prod_q <= (2*B)'(a_q) * (2*B)'(x_data);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_v    <= 1'b0;
            prod_v <= 1'b0;
            acc    <= '0;
        end else begin
            a_v    <= rd_en;
            prod_v <= a_v;
            if (clear)
                acc <= '0;
            else if (prod_v)
                acc <= acc + ACC_W'(prod_q);
        end
    end

endmodule

// File: rtl/mvm_stream.sv
// mvm_stream: streaming y = A*x engine with P parallel MAC lanes.
// Build option: define MVM_SAT_EN to saturate each result to the signed
// 2*B range; otherwise the result is the low 2*B accumulator bits.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   load_matrix/load_vector/start : command pulses, honoured only in IDLE
//                                   (priority load_matrix > load_vector > start)
//   s_valid, s_ready, s_data   : element input stream (A row-major, or x)
//   m_valid, m_ready, m_data   : result output stream, y[0]..y[K-1]
//   busy                       : high whenever the controller is not idle
//   done                       : one-cycle pulse after the last result handshake
//   fsm_state                  : current controller state
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; a valid source holds its data stable until that edge.
module mvm_stream
    import mvm_pkg::*;
#(
    parameter int K     = MVM_K,
    parameter int P     = MVM_P,
    parameter int B     = MVM_B,
    parameter int ACC_W = 2 * B + $clog2(K)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_matrix,
    input  logic           load_vector,
    input  logic           start,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [B-1:0]   s_data,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [2*B-1:0] m_data,
    output logic           busy,
    output logic           done,
    output mvm_state_t     fsm_state
);

    localparam int G     = K / P;
    localparam int DEPTH = G * K;
    localparam int CW    = cnt_w(K);
    localparam int LW    = cnt_w(P);
    localparam int GW    = cnt_w(G + 1);
    localparam int SW    = cnt_w(K + 3);
    localparam int AW    = cnt_w(DEPTH);

    mvm_state_t state, state_n;

    // col/lane/grp walk the matrix during LOAD_A (col also indexes x during
    // LOAD_X); lane/grp select the result during OUTPUT; step sequences COMPUTE.
    logic [CW-1:0] col;
    logic [LW-1:0] lane;
    logic [GW-1:0] grp;
    logic [SW-1:0] step;

    logic col_last, lane_last, grp_last;
    logic issue, clear;
    logic [AW-1:0] wr_addr, rd_addr;

    logic signed [B-1:0]     x_mem [K];
    logic signed [B-1:0]     x_q;
    logic signed [ACC_W-1:0] lane_acc [P];
    logic signed [ACC_W-1:0] acc_sel;
    logic [2*B-1:0]          result;

    assign col_last  = (col == CW'(K - 1));
    assign lane_last = (lane == LW'(P - 1));
    assign grp_last  = (grp == GW'(G - 1));

    assign wr_addr = AW'(grp) * AW'(K) + AW'(col);
    assign rd_addr = AW'(grp) * AW'(K) + AW'(step);

    assign m_valid   = (state == ST_OUTPUT);
    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

    // The accumulators are zeroed on the edge that enters COMPUTE, which
    // precedes the first product of the group by three cycles.
    assign clear = (state_n == ST_COMPUTE) && (state != ST_COMPUTE);

    always_comb begin
        state_n = state;
        s_ready = 1'b0;
        issue   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_matrix)
                    state_n = ST_LOAD_A;
                else if (load_vector)
                    state_n = ST_LOAD_X;
                else if (start)
                    state_n = ST_COMPUTE;
            end
            ST_LOAD_A: begin
                s_ready = 1'b1;
                if (s_valid && col_last && lane_last && grp_last)
                    state_n = ST_IDLE;
            end
            ST_LOAD_X: begin
                s_ready = 1'b1;
                if (s_valid && col_last)
                    state_n = ST_IDLE;
            end
            ST_COMPUTE: begin
                // Columns issue on steps 0..K-1; steps K..K+2 drain the
                // read, multiply and accumulate stages.
                issue = (step < SW'(K));
                if (step == SW'(K + 2))
                    state_n = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (m_ready && lane_last)
                    state_n = grp_last ? ST_IDLE : ST_COMPUTE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            col   <= '0;
            lane  <= '0;
            grp   <= '0;
            step  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    col  <= '0;
                    lane <= '0;
                    grp  <= '0;
                    step <= '0;
                end
                ST_LOAD_A: begin
                    if (s_valid) begin
                        col <= col_last ? '0 : col + CW'(1);
                        if (col_last) begin
                            lane <= lane_last ? '0 : lane + LW'(1);
                            if (lane_last)
                                grp <= grp + GW'(1);
                        end
                    end
                end
                ST_LOAD_X: begin
                    if (s_valid)
                        col <= col_last ? '0 : col + CW'(1);
                end
                ST_COMPUTE: begin
                    step <= (state_n == ST_OUTPUT) ? '0 : step + SW'(1);
                end
                ST_OUTPUT: begin
                    if (m_ready) begin
                        lane <= lane_last ? '0 : lane + LW'(1);
                        if (lane_last) begin
                            grp  <= grp + GW'(1);
                            done <= grp_last;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // x memory keeps its contents across reset; x_q lines up with the
    // registered bank reads in every lane.
    always_ff @(posedge clk) begin
        if (state == ST_LOAD_X && s_valid)
            x_mem[col] <= s_data;
        x_q <= x_mem[CW'(step)];
    end

    for (genvar i = 0; i < P; i++) begin : g_lane
        mvm_lane #(
            .B     (B),
            .ACC_W (ACC_W),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (state == ST_LOAD_A && s_valid && lane == LW'(i)),
            .wr_addr (wr_addr),
            .wr_data (s_data),
            .rd_en   (issue),
            .rd_addr (rd_addr),
            .x_data  (x_q),
            .clear   (clear),
            .acc     (lane_acc[i])
        );
    end

    assign acc_sel = lane_acc[lane];

`ifdef MVM_SAT_EN
    assign result = (2*B)'(sat_clip(64'(acc_sel), 2 * B));
`else
    assign result = acc_sel[2*B-1:0];
`endif

    assign m_data = m_valid ? result : '0;

endmodule

// File: tb/tb_mvm_stream.sv
module tb_mvm_stream;
    import mvm_pkg::*;

    localparam int K = 8;
    localparam int P = 2;

`ifdef MVM_SAT_EN
    localparam logic [15:0] Y_POS = 16'h7FFF;  // 129032 clamped
    localparam logic [15:0] Y_NEG = 16'h8000;  // -130048 clamped
`else
    localparam logic [15:0] Y_POS = 16'hF808;  // 129032 mod 2^16 = -2040
    localparam logic [15:0] Y_NEG = 16'h0400;  // -130048 mod 2^16 = 1024
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        load_matrix = 1'b0;
    logic        load_vector = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic        busy;
    logic        done;
    mvm_state_t  fsm_state;

    mvm_stream #(.K(K), .P(P), .B(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_matrix (load_matrix),
        .load_vector (load_vector),
        .start       (start),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .busy        (busy),
        .done        (done),
        .fsm_state   (fsm_state)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int in_hs = 0;
    int hs_count = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  a_m [K][K];
    logic [7:0]  x_v [K];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && s_valid && s_ready)
            in_hs++;
        if (!reset && m_valid && m_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL result_unexpected: got %h, expected none", m_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    n_bad++;
                    $display("FAIL result[%0d]: got %h, expected %h", hs_count, m_data, e);
                end
            end
            hs_count++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_elem(input logic [7:0] d, input int gap);
        int  w;
        bit  got;
        s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        w = 0;
        got = 1'b0;
        while (!got && w < 50) begin
            @(negedge clk);
            if (s_ready) got = 1'b1;
            else w++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        if (!got) check("s_ready_timeout", 0, 1);
    endtask

    task automatic load_a(input int gap, input bit start_during);
        int c0, h0;
        load_matrix = 1'b1;
        @(posedge clk); #1;
        load_matrix = 1'b0;
        c0 = cyc;
        h0 = in_hs;
        for (int i = 0; i < K * K; i++) begin
            start = start_during && (i < K * K - 1);
            send_elem(a_m[i / K][i % K], (i == 0) ? 0 : gap);
        end
        start = 1'b0;
        @(negedge clk);
        check("load_a_handshakes", in_hs - h0, K * K);
        check("load_a_s_ready_low", s_ready, 0);
        check("load_a_busy_low", busy, 0);
        if (gap == 0) check("load_a_cycles", cyc - c0, K * K);
        @(posedge clk); #1;
    endtask

    task automatic load_x(input int gap);
        int h0;
        load_vector = 1'b1;
        @(posedge clk); #1;
        load_vector = 1'b0;
        h0 = in_hs;
        for (int i = 0; i < K; i++)
            send_elem(x_v[i], (i == 0) ? 0 : gap);
        @(negedge clk);
        check("load_x_handshakes", in_hs - h0, K);
        check("load_x_s_ready_low", s_ready, 0);
        @(posedge clk); #1;
    endtask

    // Starts a computation and drives m_ready; optionally withholds m_ready for
    // hold_len cycles once hold_at results have been taken.
    task automatic run_compute(input int hold_at, input int hold_len,
                               input logic [15:0] hold_val);
        int n, first_v, held, lh, last_h;
        bit prev_v, seen_done;
        first_v = -1; held = 0; lh = 0; last_h = -1;
        prev_v = 1'b0; seen_done = 1'b0; n = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!seen_done && n < 400) begin
            m_ready = !(m_valid && lh == hold_at && held < hold_len);
            @(negedge clk);
            if (m_valid && !prev_v) begin
                if (first_v < 0) first_v = n;
                else check("group_gap", n - last_h, K + 3);
            end
            prev_v = m_valid;
            if (!m_ready && lh == hold_at) begin
                held++;
                check("hold_m_valid", m_valid, 1);
                check("hold_m_data", m_data, hold_val);
            end
            if (m_valid && m_ready) begin
                lh++;
                if (lh % P == 0) last_h = n + 1;
            end
            if (done) begin
                seen_done = 1'b1;
                check("done_busy_low", busy, 0);
                check("done_results", lh, K);
                check("done_queue_empty", exp_q.size(), 0);
            end
            @(posedge clk); #1;
            n++;
        end
        m_ready = 1'b1;
        if (!seen_done) begin
            check("done_timeout", 0, 1);
        end else begin
            @(negedge clk);
            check("done_one_cycle", done, 0);
            @(posedge clk); #1;
        end
        check("first_valid_latency", first_v, K + 3);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int c = 0; c < K; c++) x_v[c] = 8'(c + 1);

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_s_ready", s_ready, 0);
        check("reset_m_valid", m_valid, 0);
        check("reset_m_data", m_data, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        m_ready = 1'b1;
        @(posedge clk); #1;

        // Identity matrix, x = 1..8: y = x.
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                a_m[r][c] = (r == c) ? 8'd1 : 8'd0;
        load_a(0, 1'b0);
        load_x(0);
        for (int i = 0; i < K; i++) exp_q.push_back(16'(i + 1));
        run_compute(-1, 0, 16'd0);

        // Same data from the retained memories, result 2 held back 5 cycles.
        for (int i = 0; i < K; i++) exp_q.push_back(16'(i + 1));
        run_compute(1, 5, 16'd2);

        // Band matrix (2 on diagonal, -1 above), start held during a gappy
        // load: y[r] = 2(r+1) - (r+2) = r for r < 7, y[7] = 16.
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                a_m[r][c] = (r == c) ? 8'd2 : ((c == r + 1) ? 8'hFF : 8'd0);
        load_a(1, 1'b1);
        exp_q.push_back(16'd0); exp_q.push_back(16'd1);
        exp_q.push_back(16'd2); exp_q.push_back(16'd3);
        exp_q.push_back(16'd4); exp_q.push_back(16'd5);
        exp_q.push_back(16'd6); exp_q.push_back(16'd16);
        run_compute(-1, 0, 16'd0);

        // All 127 times 127: y = 129032, beyond the 16-bit range.
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                a_m[r][c] = 8'd127;
        for (int c = 0; c < K; c++) x_v[c] = 8'd127;
        load_a(0, 1'b0);
        load_x(1);
        for (int i = 0; i < K; i++) exp_q.push_back(Y_POS);
        run_compute(-1, 0, 16'd0);

        // All -128 times 127: y = -130048.
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                a_m[r][c] = 8'h80;
        load_a(0, 1'b0);
        for (int i = 0; i < K; i++) exp_q.push_back(Y_NEG);
        run_compute(-1, 0, 16'd0);

        // Reset in the middle of COMPUTE, then rerun on the retained data.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_m_valid", m_valid, 0);
        check("abort_s_ready", s_ready, 0);
        @(posedge clk); #1;
        for (int i = 0; i < K; i++) exp_q.push_back(Y_NEG);
        run_compute(-1, 0, 16'd0);

        check("final_result_count", hs_count, 6 * K);
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mvm_stream.md
# mvm_stream

Parametrised streaming matrix-vector multiplier: computes y = A·x for a signed K×K matrix A and K-vector x using P parallel MAC lanes. Matrix and vector are loaded through a valid/ready input stream, and results leave through a valid/ready output stream with backpressure. It is the next-generation top-level MVM engine, generalising lane count independently of K and adding flow control, busy/done status and optional output saturation.

## Interface
- K, 8: matrix/vector dimension; K % P == 0 required.
- P, 2: MAC lanes (rows computed concurrently).
- B, 8: signed input element width.
- ACC_W, 2*B+$clog2(K): internal accumulator width; never overflows.
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- load_matrix  in  1  pulse; start matrix load (honoured only in IDLE).
- load_vector  in  1  pulse; start vector load (honoured only in IDLE).
- start  in  1  pulse; start computation (honoured only in IDLE).
- s_valid  in  1  input element valid.
- s_ready  out  1  input element accepted when s_valid && s_ready.
- s_data  in  B  signed input element.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- m_data  out  2*B  signed result y[r].
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after the last result handshake.

## Operation
- States: IDLE, LOAD_A, LOAD_X, COMPUTE, OUTPUT.
- IDLE command priority when several are asserted together: load_matrix > load_vector > start. Commands arriving outside IDLE are ignored.
- LOAD_A: s_ready=1. Accepts exactly K*K elements, row-major. Element (r,c) is written to lane r%P at address (r/P)*K+c. After the last element → IDLE.
- LOAD_X: s_ready=1. Accepts exactly K elements into the shared X memory, address c. After the last element → IDLE.
- s_valid gaps are allowed; the element counter advances only on a handshake.
- COMPUTE: processes row group g (rows g*P..g*P+P-1) for g = 0..K/P-1. Issues column addresses 0..K-1, then waits for the pipeline to drain; each lane accumulates A[r][c]*x[c]. The accumulator is cleared at the start of each group. → OUTPUT.
- OUTPUT: presents lane 0..P-1 results of group g in row order, one per handshake. After the last lane of the group: next group → COMPUTE; last group → IDLE with done pulse.
- Result conversion from ACC_W to 2*B: see Configuration.
- Memories retain contents across commands and reset. Start without a prior load computes on stale or undefined data, with no error flagged.
- Reset mid-operation: → IDLE immediately; counters cleared; any partial load or compute is abandoned.

## Timing
- Reset values: s_ready=0, m_valid=0, m_data=0, busy=0, done=0.
- Memory read latency: 1 cycle. Multiply register: 1 cycle. Accumulate register: 1 cycle.
- The edge that samples start is t0. The first m_valid rises at t0+K+3.
- Each subsequent group's m_valid rises K+3 cycles after the final handshake of the previous group.
- m_valid/m_data hold stable while m_ready=0. The next result appears the cycle after a handshake.
- done is high exactly the cycle after the final y[K-1] handshake; busy drops in that same cycle.
- Load throughput: one element per cycle while s_valid is held high.
- s_ready drops the cycle after the last element is accepted.

## Configuration
- MVM_SAT_EN defined: the result saturates to the signed 2*B range: values above the range give 2^(2B-1)-1, values below give -2^(2B-1).
- MVM_SAT_EN undefined: the result is the low 2*B bits of the accumulator (two's-complement wrap).

## Structure
- Package mvm_pkg holds:
  - the state enum typedef (mvm_state_t);
  - localparams for counter widths ($clog2(K*K), $clog2(K), $clog2(K/P+1));
  - the saturation function.
- Sub-module mvm_lane, instantiated P times. Each holds one A bank of (K/P)*K words, a multiply register and an accumulator with synchronous clear.
- The X memory, FSM, counters and output mux live in mvm_stream.

## Test plan
- K=4,P=2,B=8: A=identity, x=[1,2,3,4], m_ready=1 → outputs 1,2,3,4; first m_valid at t0+7; done pulse after the 4th result.
- K=8,P=2,B=8: A all 127, x all 127 → every y = 129032; with MVM_SAT_EN 32767, without it -2040 (0xF808).
- K=8: A all -128, x all 127 → with MVM_SAT_EN every y = -32768 (0x8000).
- Identity test with m_ready held low 5 cycles on result 2 → m_data stays 2 and m_valid stays high; the sequence completes with no loss or duplication.
- start asserted during LOAD_A, and s_valid toggling every other cycle → start ignored; load completes after exactly 16 handshakes (K=4).
- reset during COMPUTE → next cycle busy=0, m_valid=0; a following start re-runs and yields correct results from the retained memories.
